brg_cgra_link_arbiter: RTL and testbench



---
 rtl/brg_cgra_link_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_brg_cgra_link_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brg_cgra_link_arbiter.sv
// rtl/brg_cgra_link_arbiter.sv - N-channel link concentrator onto one accelerator port
// Buffered, credit-limited round-robin request arbitration with y-steered responses.
module brg_cgra_link_arbiter #(
    parameter int num_links_p       = 4,
    parameter int fwd_width_p       = 32,
    parameter int rev_width_p       = 32,
    parameter int y_cord_width_p    = 7,
    parameter int resp_y_lsb_p      = 0,
    parameter int fifo_depth_p      = 2,
    parameter int max_out_credits_p = 32
) (
    input  logic                                                   clk_i,
    input  logic                                                   reset_n_i,
    input  logic [num_links_p*y_cord_width_p-1:0]                  link_y_cord_i,
    input  logic [num_links_p-1:0]                                 req_v_i,
    input  logic [num_links_p*fwd_width_p-1:0]                     req_data_i,
    output logic [num_links_p-1:0]                                 req_ready_o,
    output logic                                                   xcel_req_v_o,
    output logic [fwd_width_p-1:0]                                 xcel_req_data_o,
    output logic [$clog2(num_links_p)-1:0]                         xcel_req_src_o,
    input  logic                                                   xcel_req_ready_i,
    input  logic                                                   xcel_resp_v_i,
    input  logic [rev_width_p-1:0]                                 xcel_resp_data_i,
    output logic                                                   xcel_resp_ready_o,
    output logic [num_links_p-1:0]                                 resp_v_o,
    output logic [num_links_p*rev_width_p-1:0]                     resp_data_o,
    input  logic [num_links_p-1:0]                                 resp_ready_i,
    output logic [num_links_p*$clog2(max_out_credits_p+1)-1:0]     outstanding_o,
    output logic [15:0]                                            drop_count_o
);

    localparam int src_w = $clog2(num_links_p);
    localparam int out_w = $clog2(max_out_credits_p + 1);
    localparam int ptr_w = $clog2(fifo_depth_p);
    localparam int cnt_w = $clog2(fifo_depth_p + 1);

    localparam logic [ptr_w-1:0] last_slot  = ptr_w'(fifo_depth_p - 1);
    localparam logic [cnt_w-1:0] full_count = cnt_w'(fifo_depth_p);
    localparam logic [out_w-1:0] max_credit = out_w'(max_out_credits_p);
    localparam logic [src_w-1:0] last_link  = src_w'(num_links_p - 1);

    logic [num_links_p-1:0]             eligible;
    logic [num_links_p*fwd_width_p-1:0] head_flat;
    logic [src_w-1:0]                   ptr;
    logic [src_w-1:0]                   grant;
    logic                               grant_found;
    logic                               load;
    logic                               take;

    logic                               rsp_full;
    logic [rev_width_p-1:0]             rsp_data;
    logic [src_w-1:0]                   rsp_tgt;
    logic                               deliver;
    logic                               accept;
    logic [y_cord_width_p-1:0]          resp_y;
    logic                               hit;
    logic [src_w-1:0]                   hit_idx;
    logic [out_w-1:0]                   hit_outst;
    logic                               hit_dec;
    logic                               keep;

    // Per-channel request FIFO and outstanding-credit counter.
    for (genvar i = 0; i < num_links_p; i++) begin : g_link
        logic [fwd_width_p-1:0] mem [fifo_depth_p];
        logic [ptr_w-1:0]       rd_ptr;
        logic [ptr_w-1:0]       wr_ptr;
        logic [cnt_w-1:0]       count;
        logic [out_w-1:0]       outst;
        logic                   push;
        logic                   pop;
        logic                   ret;

        assign req_ready_o[i] = reset_n_i & (count != full_count);
        assign push           = req_v_i[i] & req_ready_o[i];
        assign pop            = take & (grant == src_w'(i));
        assign ret            = resp_v_o[i] & resp_ready_i[i];
        assign eligible[i]    = (count != '0) & (outst < max_credit);
        assign head_flat[i*fwd_width_p +: fwd_width_p] = mem[rd_ptr];
        assign outstanding_o[i*out_w +: out_w]         = outst;
        assign resp_v_o[i]    = rsp_full & (rsp_tgt == src_w'(i));
        assign resp_data_o[i*rev_width_p +: rev_width_p] = rsp_data;

        always_ff @(posedge clk_i) begin
            if (push) begin
                mem[wr_ptr] <= req_data_i[i*fwd_width_p +: fwd_width_p];
            end
        end

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                outst  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == last_slot) ? '0 : wr_ptr + ptr_w'(1);
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == last_slot) ? '0 : rd_ptr + ptr_w'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + cnt_w'(1);
                    2'b01:   count <= count - cnt_w'(1);
                    default: count <= count;
                endcase
                case ({pop, ret})
                    2'b10:   outst <= outst + out_w'(1);
                    2'b01:   outst <= outst - out_w'(1);
                    default: outst <= outst;
                endcase
            end
        end
    end

    // Round-robin scan starting at ptr, wrapping modulo num_links_p.
    always_comb begin : arb
        int idx;
        grant_found = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int k = 0; k < num_links_p; k++) begin
            idx = int'(ptr) + k;
            if (idx >= num_links_p) begin
                idx = idx - num_links_p;
            end
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                grant       = idx[src_w-1:0];
            end
        end
    end

    assign load = ~xcel_req_v_o | xcel_req_ready_i;
    assign take = load & grant_found;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            xcel_req_v_o    <= 1'b0;
            xcel_req_data_o <= '0;
            xcel_req_src_o  <= '0;
            ptr             <= '0;
        end else if (load) begin
            xcel_req_v_o <= grant_found;
            if (grant_found) begin
                xcel_req_data_o <= head_flat[int'(grant)*fwd_width_p +: fwd_width_p];
                xcel_req_src_o  <= grant;
                ptr             <= (grant == last_link) ? '0 : grant + src_w'(1);
            end
        end
    end

    assign deliver           = rsp_full & resp_ready_i[rsp_tgt];
    assign xcel_resp_ready_o = reset_n_i & (~rsp_full | resp_ready_i[rsp_tgt]);
    assign accept            = xcel_resp_v_i & xcel_resp_ready_o;
    assign resp_y            = xcel_resp_data_i[resp_y_lsb_p +: y_cord_width_p];

    // Lowest-numbered channel owning the response's y coordinate wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < num_links_p; i++) begin
            if (!hit && (link_y_cord_i[i*y_cord_width_p +: y_cord_width_p] == resp_y)) begin
                hit     = 1'b1;
                hit_idx = src_w'(i);
            end
        end
    end

    assign hit_outst = outstanding_o[int'(hit_idx)*out_w +: out_w];
    assign hit_dec   = deliver & (rsp_tgt == hit_idx);
    assign keep      = hit & (hit_outst != out_w'(hit_dec));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rsp_full     <= 1'b0;
            rsp_data     <= '0;
            rsp_tgt      <= '0;
            drop_count_o <= '0;
        end else begin
            if (accept && keep) begin
                rsp_full <= 1'b1;
                rsp_data <= xcel_resp_data_i;
                rsp_tgt  <= hit_idx;
            end else if (deliver) begin
                rsp_full <= 1'b0;
            end
            if (accept && !keep && (drop_count_o != 16'hFFFF)) begin
                drop_count_o <= drop_count_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_brg_cgra_link_arbiter.sv
// tb/tb_brg_cgra_link_arbiter.sv - self-checking bench for brg_cgra_link_arbiter
// Queue-level reference model compared against every output each cycle, plus directed scenarios.
module tb_brg_cgra_link_arbiter;

    localparam int N     = 4;
    localparam int FW    = 32;
    localparam int RW    = 32;
    localparam int YW    = 7;
    localparam int DEPTH = 2;
    localparam int MAXC  = 2;
    localparam int SW    = $clog2(N);
    localparam int OW    = $clog2(MAXC + 1);

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic [N*YW-1:0]   link_y_cord_i;
    logic [N-1:0]      req_v_i;
    logic [N*FW-1:0]   req_data_i;
    logic [N-1:0]      req_ready_o;
    logic              xcel_req_v_o;
    logic [FW-1:0]     xcel_req_data_o;
    logic [SW-1:0]     xcel_req_src_o;
    logic              xcel_req_ready_i;
    logic              xcel_resp_v_i;
    logic [RW-1:0]     xcel_resp_data_i;
    logic              xcel_resp_ready_o;
    logic [N-1:0]      resp_v_o;
    logic [N*RW-1:0]   resp_data_o;
    logic [N-1:0]      resp_ready_i;
    logic [N*OW-1:0]   outstanding_o;
    logic [15:0]       drop_count_o;

    always #5 clk_i = ~clk_i;

    brg_cgra_link_arbiter #(
        .num_links_p(N), .fwd_width_p(FW), .rev_width_p(RW), .y_cord_width_p(YW),
        .resp_y_lsb_p(0), .fifo_depth_p(DEPTH), .max_out_credits_p(MAXC)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .link_y_cord_i(link_y_cord_i),
        .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .xcel_req_v_o(xcel_req_v_o), .xcel_req_data_o(xcel_req_data_o),
        .xcel_req_src_o(xcel_req_src_o), .xcel_req_ready_i(xcel_req_ready_i),
        .xcel_resp_v_i(xcel_resp_v_i), .xcel_resp_data_i(xcel_resp_data_i),
        .xcel_resp_ready_o(xcel_resp_ready_o), .resp_v_o(resp_v_o),
        .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
        .outstanding_o(outstanding_o), .drop_count_o(drop_count_o)
    );

    // Reference model state
    logic [FW-1:0] mq [N][$];
    int            m_ptr;
    int            m_outst [N];
    int            m_drop;
    bit            m_out_v;
    logic [FW-1:0] m_out_data;
    int            m_out_src;
    bit            m_rsp_v;
    logic [RW-1:0] m_rsp_data;
    int            m_rsp_tgt;
    int            ycord [N];

    int n_cmp = 0;
    int n_bad = 0;
    int gsrc [$];
    bit last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_xrr();
        return reset_n_i && (!m_rsp_v || resp_ready_i[m_rsp_tgt]);
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("req_ready[%0d]", i), 64'(req_ready_o[i]),
                64'(reset_n_i && (mq[i].size() < DEPTH)));
            chk($sformatf("resp_v[%0d]", i), 64'(resp_v_o[i]), 64'(m_rsp_v && (m_rsp_tgt == i)));
            chk($sformatf("outstanding[%0d]", i), 64'(outstanding_o[i*OW +: OW]), 64'(m_outst[i]));
        end
        chk("xreq_v", 64'(xcel_req_v_o), 64'(m_out_v));
        if (m_out_v) begin
            chk("xreq_data", 64'(xcel_req_data_o), 64'(m_out_data));
            chk("xreq_src", 64'(xcel_req_src_o), 64'(m_out_src));
        end
        if (m_rsp_v) chk("resp_data", 64'(resp_data_o[m_rsp_tgt*RW +: RW]), 64'(m_rsp_data));
        chk("xresp_ready", 64'(xcel_resp_ready_o), 64'(exp_xrr()));
        chk("drop_count", 64'(drop_count_o), 64'(m_drop));
    endtask

    task automatic model_advance();
        bit            deliver, accept, found, match;
        bit [N-1:0]    push;
        int            g, tgt, dtgt, net, y;
        if (!reset_n_i) begin
            for (int i = 0; i < N; i++) begin mq[i].delete(); m_outst[i] = 0; end
            m_ptr = 0; m_drop = 0; m_out_v = 0; m_rsp_v = 0;
            return;
        end
        deliver = m_rsp_v && resp_ready_i[m_rsp_tgt];
        dtgt    = m_rsp_tgt;
        accept  = xcel_resp_v_i && exp_xrr();
        for (int i = 0; i < N; i++) push[i] = req_v_i[i] && (mq[i].size() < DEPTH);
        found = 0; g = 0;
        if (!m_out_v || xcel_req_ready_i) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && mq[c].size() > 0 && m_outst[c] < MAXC) begin found = 1; g = c; end
            end
            m_out_v = found;
            if (found) begin
                m_out_data = mq[g].pop_front();
                m_out_src  = g;
                m_ptr      = (g + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) if (push[i]) mq[i].push_back(req_data_i[i*FW +: FW]);
        if (accept) begin
            y = int'(xcel_resp_data_i[YW-1:0]);
            match = 0; tgt = 0;
            for (int i = 0; i < N; i++) if (!match && ycord[i] == y) begin match = 1; tgt = i; end
            net = m_outst[tgt] - ((deliver && dtgt == tgt) ? 1 : 0);
            if (!match || net == 0) begin
                if (m_drop < 65535) m_drop++;
                if (deliver) m_rsp_v = 0;
            end else begin
                m_rsp_v = 1; m_rsp_data = xcel_resp_data_i; m_rsp_tgt = tgt;
            end
        end else if (deliver) begin
            m_rsp_v = 0;
        end
        if (found) m_outst[g]++;
        if (deliver) m_outst[dtgt]--;
    endtask

    task automatic step();
        #1;
        check_outputs();
        last_acc = xcel_resp_v_i && xcel_resp_ready_o;
        if (xcel_req_v_o && xcel_req_ready_i) gsrc.push_back(int'(xcel_req_src_o));
        model_advance();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic push_req(input int ch, input logic [FW-1:0] d);
        req_v_i[ch] = 1'b1;
        req_data_i[ch*FW +: FW] = d;
        step();
        req_v_i[ch] = 1'b0;
    endtask

    task automatic send_resp(input int y, output logic [RW-1:0] d);
        bit got;
        got = 0;
        d = $urandom();
        d[YW-1:0] = YW'(y);
        xcel_resp_v_i = 1'b1;
        xcel_resp_data_i = d;
        for (int t = 0; t < 20 && !got; t++) begin step(); got = last_acc; end
        xcel_resp_v_i = 1'b0;
        chk("resp_accept", 64'(got), 64'd1);
    endtask

    task automatic drain();
        bit idle;
        int c;
        logic [RW-1:0] d;
        xcel_req_ready_i = 1'b1; resp_ready_i = '1; req_v_i = '0; xcel_resp_v_i = 1'b0;
        idle = 0;
        for (int t = 0; t < 80 && !idle; t++) begin
            c = -1;
            for (int i = 0; i < N; i++)
                if (c < 0 && (m_outst[i] - ((m_rsp_v && m_rsp_tgt == i) ? 1 : 0)) > 0) c = i;
            idle = (c < 0) && !m_rsp_v && !m_out_v;
            for (int i = 0; i < N; i++) if (mq[i].size() > 0) idle = 0;
            if (c >= 0) send_resp(ycord[c], d);
            else if (!idle) step();
        end
        chk("drain_idle", 64'(idle), 64'd1);
    endtask

    initial begin
        logic [RW-1:0] d1, d2, dd;
        int sent, ch0_grants, exp_drop, c;
        bit acc, saw_full;

        reset_n_i = 1'b0; req_v_i = '0; req_data_i = '0; xcel_req_ready_i = 1'b0;
        xcel_resp_v_i = 1'b0; xcel_resp_data_i = '0; resp_ready_i = '1;
        for (int i = 0; i < N; i++) begin
            ycord[i] = i;
            link_y_cord_i[i*YW +: YW] = YW'(i);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        step();
        chk("rst_xreq_v", 64'(xcel_req_v_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        reset_n_i = 1'b1;
        step();

        // Round-robin over preloaded FIFOs, then pointer wrap
        req_v_i = '1;
        for (int i = 0; i < N; i++) req_data_i[i*FW +: FW] = 32'h100 + i;
        step();
        req_v_i = '0;
        step();
        gsrc.delete();
        xcel_req_ready_i = 1'b1;
        repeat (6) step();
        chk("rr_count", 64'(gsrc.size()), 64'd4);
        for (int i = 0; i < 4 && i < gsrc.size(); i++) chk($sformatf("rr_src%0d", i), 64'(gsrc[i]), 64'(i));
        gsrc.delete();
        req_v_i = 4'b0101;
        req_data_i[0 +: FW] = 32'h200; req_data_i[2*FW +: FW] = 32'h202;
        step();
        req_v_i = '0;
        repeat (4) step();
        chk("wrap_count", 64'(gsrc.size()), 64'd2);
        if (gsrc.size() == 2) begin
            chk("wrap_first", 64'(gsrc[0]), 64'd0);
            chk("wrap_second", 64'(gsrc[1]), 64'd2);
        end
        drain();

        // Request latency
        push_req(1, 32'hCAFE0001);
        chk("lat_early_v", 64'(xcel_req_v_o), 64'd0);
        step();
        chk("lat_v", 64'(xcel_req_v_o), 64'd1);
        chk("lat_src", 64'(xcel_req_src_o), 64'd1);
        chk("lat_data", 64'(xcel_req_data_o), 64'hCAFE0001);
        chk("lat_outst", 64'(outstanding_o[1*OW +: OW]), 64'd1);
        drain();

        // Credit exhaustion on channel 0
        gsrc.delete(); sent = 0; saw_full = 0;
        for (int t = 0; t < 12; t++) begin
            req_v_i[0] = (sent < 5);
            req_data_i[0 +: FW] = 32'h500 + sent;
            #1 acc = req_v_i[0] && req_ready_o[0];
            if (!req_ready_o[0]) saw_full = 1;
            step();
            if (acc) sent++;
        end
        ch0_grants = 0;
        foreach (gsrc[i]) if (gsrc[i] == 0) ch0_grants++;
        chk("credit_grants", 64'(ch0_grants), 64'd2);
        chk("credit_accepted", 64'(sent), 64'd4);
        chk("credit_full_seen", 64'(saw_full), 64'd1);
        send_resp(0, dd);
        req_v_i[0] = 1'b0;
        step();
        chk("credit_wait_v", 64'(xcel_req_v_o), 64'd0);
        step();
        chk("credit_grant_v", 64'(xcel_req_v_o), 64'd1);
        chk("credit_grant_src", 64'(xcel_req_src_o), 64'd0);
        drain();

        // Steering by y, then an unmatched y
        push_req(2, 32'h2222);
        repeat (3) step();
        send_resp(2, d1);
        chk("steer_v2", 64'(resp_v_o[2]), 64'd1);
        chk("steer_data", 64'(resp_data_o[2*RW +: RW]), 64'(d1));
        step();
        chk("steer_outst", 64'(outstanding_o[2*OW +: OW]), 64'd0);
        exp_drop = m_drop + 1;
        send_resp(9, dd);
        chk("drop_count_inc", 64'(drop_count_o), 64'(exp_drop));
        #1 chk("drop_ready", 64'(xcel_resp_ready_o), 64'd1);
        drain();

        // Response back-pressure on channel 2
        push_req(2, 32'h3001);
        push_req(2, 32'h3002);
        repeat (3) step();
        resp_ready_i[2] = 1'b0;
        send_resp(2, d1);
        d2 = $urandom(); d2[YW-1:0] = YW'(2);
        xcel_resp_v_i = 1'b1; xcel_resp_data_i = d2;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("hold_xrr", 64'(xcel_resp_ready_o), 64'd0);
            chk("hold_data", 64'(resp_data_o[2*RW +: RW]), 64'(d1));
        end
        resp_ready_i[2] = 1'b1;
        step();
        chk("release_accept", 64'(last_acc), 64'd1);
        xcel_resp_v_i = 1'b0;
        chk("release_next_data", 64'(resp_data_o[2*RW +: RW]), 64'(d2));
        drain();

        // Reset with traffic in flight
        xcel_req_ready_i = 1'b0;
        req_v_i = 4'b1010;
        req_data_i[1*FW +: FW] = 32'h7001; req_data_i[3*FW +: FW] = 32'h7003;
        step();
        req_v_i = '0;
        step();
        c = 0;
        for (int i = 0; i < N; i++) if (m_outst[i] > 0) c = i;
        resp_ready_i = '0;
        send_resp(ycord[c], dd);
        reset_n_i = 1'b0;
        step();
        reset_n_i = 1'b1;
        chk("mid_rst_xreq_v", 64'(xcel_req_v_o), 64'd0);
        chk("mid_rst_resp_v", 64'(resp_v_o), 64'd0);
        chk("mid_rst_outst", 64'(outstanding_o), 64'd0);
        chk("mid_rst_drop", 64'(drop_count_o), 64'd0);
        xcel_req_ready_i = 1'b1; resp_ready_i = '1;
        gsrc.delete();
        repeat (6) step();
        chk("mid_rst_no_stale", 64'(gsrc.size()), 64'd0);

        // Randomised traffic
        for (int t = 0; t < 800; t++) begin
            req_v_i = N'($urandom());
            for (int i = 0; i < N; i++) req_data_i[i*FW +: FW] = $urandom();
            xcel_req_ready_i = ($urandom_range(0, 3) != 0);
            resp_ready_i = N'($urandom());
            xcel_resp_v_i = $urandom_range(0, 1);
            dd = $urandom(); dd[YW-1:0] = YW'($urandom_range(0, 5));
            xcel_resp_data_i = dd;
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
